// File: rtl/triangle_raster_if.sv
// Pixel stream between the triangle rasterizer and the frame-buffer writer.
// The rasterizer drives the master side, the frame-buffer writer the slave side.
interface triangle_raster_if #(
   parameter int W = 11
);
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_x;
   logic [W-1:0] out_y;

   modport master (
      output out_valid,
      output out_x,
      output out_y,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_x,
      input  out_y,
      output out_ready
   );
endinterface

// File: rtl/triangle_raster.sv
// Triangle rasterizer: walks the bounding box of three vertices in row-major
// order and streams every pixel that passes the edge-sign inside test.
// Optional feature: define RASTER_COUNT_EN to add the pix_count output, a
// running count of accepted pixels for the current triangle.
module triangle_raster #(
   parameter int W = 11
) (
   input  logic          CLOCK,
   input  logic          reset,
   input  logic          start,
   input  logic [W-1:0]  p1x,
   input  logic [W-1:0]  p1y,
   input  logic [W-1:0]  p2x,
   input  logic [W-1:0]  p2y,
   input  logic [W-1:0]  p3x,
   input  logic [W-1:0]  p3y,
   output logic          busy,
   output logic          done,
   triangle_raster_if.master pix
`ifdef RASTER_COUNT_EN
   ,
   output logic [2*W-1:0] pix_count
`endif
);

   typedef enum logic [1:0] {IDLE, SETUP, SCAN, DRAIN} state_t;

   state_t       state;
   logic [W-1:0] v1x, v1y, v2x, v2y, v3x, v3y;
   logic [W-1:0] xmin, xmax, ymin, ymax;
   logic [W-1:0] cx, cy;
   logic         out_valid_q;
   logic [W-1:0] out_x_q, out_y_q;

   logic [W-1:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
   logic         s12, s23, s31;
   logic         inside_now;
   logic         stall;
   logic         accepted;

   assign pix.out_valid = out_valid_q;
   assign pix.out_x     = out_x_q;
   assign pix.out_y     = out_y_q;

   function automatic logic [W-1:0] min3(input logic [W-1:0] a, b, c);
      logic [W-1:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   function automatic logic [W-1:0] max3(input logic [W-1:0] a, b, c);
      logic [W-1:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Edge sign for edge (a,b) and point t; differences are one bit wider and
   // products twice that, so the signed compare can never overflow.
   function automatic logic edge_s(input logic [W-1:0] ax, ay, bx, by, tx, ty);
      logic signed [W:0]     dtx, day, dax, dty;
      logic signed [2*W+1:0] m1, m2;
      dtx = $signed({1'b0, tx}) - $signed({1'b0, bx});
      day = $signed({1'b0, ay}) - $signed({1'b0, by});
      dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
      dty = $signed({1'b0, ty}) - $signed({1'b0, by});
      m1  = (2*W+2)'(dtx) * (2*W+2)'(day);
      m2  = (2*W+2)'(dax) * (2*W+2)'(dty);
      return (m1 < m2);
   endfunction

   // Bounding box of the captured vertices and the inside test for (cx,cy).
   always_comb begin
      bb_xmin    = min3(v1x, v2x, v3x);
      bb_xmax    = max3(v1x, v2x, v3x);
      bb_ymin    = min3(v1y, v2y, v3y);
      bb_ymax    = max3(v1y, v2y, v3y);
      s12        = edge_s(v1x, v1y, v2x, v2y, cx, cy);
      s23        = edge_s(v2x, v2y, v3x, v3y, cx, cy);
      s31        = edge_s(v3x, v3y, v1x, v1y, cx, cy);
      inside_now = (s12 == s23) && (s23 == s31);
      stall      = out_valid_q && !pix.out_ready;
      accepted   = out_valid_q && pix.out_ready;
   end

   // Control FSM: capture, bounding-box setup, scan one candidate per cycle,
   // then drain the last pixel before pulsing done.
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         out_valid_q <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         v1x         <= '0;
         v1y         <= '0;
         v2x         <= '0;
         v2y         <= '0;
         v3x         <= '0;
         v3y         <= '0;
         xmin        <= '0;
         xmax        <= '0;
         ymin        <= '0;
         ymax        <= '0;
         cx          <= '0;
         cy          <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  v1x   <= p1x;
                  v1y   <= p1y;
                  v2x   <= p2x;
                  v2y   <= p2y;
                  v3x   <= p3x;
                  v3y   <= p3y;
                  busy  <= 1'b1;
                  state <= SETUP;
               end
            end
            SETUP: begin
               xmin  <= bb_xmin;
               xmax  <= bb_xmax;
               ymin  <= bb_ymin;
               ymax  <= bb_ymax;
               cx    <= bb_xmin;
               cy    <= bb_ymin;
               state <= SCAN;
            end
            SCAN: begin
               if (!stall) begin
                  out_valid_q <= inside_now;
                  out_x_q     <= cx;
                  out_y_q     <= cy;
                  if (cx == xmax) begin
                     cx <= xmin;
                     cy <= cy + 1'b1;
                  end else begin
                     cx <= cx + 1'b1;
                  end
                  if (cx == xmax && cy == ymax) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (!stall) begin
                  out_valid_q <= 1'b0;
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RASTER_COUNT_EN
   // Accepted-pixel counter, restarted whenever a new triangle is accepted.
   always_ff @(posedge CLOCK or negedge reset) begin
      if (!reset) begin
         pix_count <= '0;
      end else if (state == IDLE && start) begin
         pix_count <= '0;
      end else if (accepted) begin
         pix_count <= pix_count + 1'b1;
      end
   end
`else
   logic unused_accepted;
   assign unused_accepted = accepted;
`endif

endmodule
